lvds_word_align: RTL

Receive-side word aligner between the 4-lane 7:1 LVDS deserializer and the core logic, in the `clkdiv` domain. It consumes the 28-bit parallel word, trains each lane independently against a fixed training pattern by pulsing per-lane bitslip requests back to the deserializer, and declares link lock when all lanes are aligned. Until lock, downstream data is forced to zero; after lock, data passes through with one cycle of latency.

---
 rtl/lvds_word_align.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/lvds_word_align.sv
// Per-lane word aligner for a 4-lane 7:1 LVDS receiver: trains each lane against a
// fixed pattern using bitslip pulses, then gates the parallel word until all lanes lock.
module lvds_word_align #(
  parameter logic [6:0] TRAIN_PATTERN = 7'b1100011,
  parameter int         SLIP_WAIT     = 3,
  parameter int         LOCK_CNT      = 16,
  parameter int         MAX_SLIPS     = 14
) (
  input  logic        clkdiv,
  input  logic        rst,
  input  logic [27:0] dat_in,
  input  logic        retrain,
  output logic [3:0]  bitslip,
  output logic [3:0]  aligned,
  output logic [3:0]  train_err,
  output logic        lock,
  output logic [27:0] dat_out,
  output logic        dat_valid
);

  typedef enum logic [2:0] {
    ST_SEARCH = 3'd0,
    ST_WAIT   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } lane_state_t;

  localparam logic [3:0] WAIT_INIT = 4'(SLIP_WAIT);
  localparam logic [7:0] LOCK_TGT  = 8'(LOCK_CNT);
  localparam logic [5:0] SLIP_MAX  = 6'(MAX_SLIPS);

  lane_state_t state_r     [4];
  lane_state_t state_s     [4];
  logic [3:0]  wait_cnt_r  [4];
  logic [3:0]  wait_cnt_s  [4];
  logic [7:0]  match_cnt_r [4];
  logic [7:0]  match_cnt_s [4];
  logic [5:0]  slip_cnt_r  [4];
  logic [5:0]  slip_cnt_s  [4];
  logic [3:0]  lane_hit_s;
  logic [3:0]  bitslip_s;
  logic [3:0]  bitslip_r;
  logic [3:0]  aligned_r;
  logic [3:0]  train_err_r;
  logic        lock_r;
  logic [27:0] dat_out_r;
  logic        dat_valid_r;

  // Compare each lane's 7-bit slice against the training pattern
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_hit_s[i] = (dat_in[7*i +: 7] == TRAIN_PATTERN);
    end
  end

  // Per-lane next-state, counter and bitslip decode; retrain overrides everything
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_s[i]     = state_r[i];
      wait_cnt_s[i]  = wait_cnt_r[i];
      match_cnt_s[i] = match_cnt_r[i];
      slip_cnt_s[i]  = slip_cnt_r[i];
      bitslip_s[i]   = 1'b0;
      if (retrain) begin
        state_s[i]     = ST_SEARCH;
        wait_cnt_s[i]  = 4'd0;
        match_cnt_s[i] = 8'd0;
        slip_cnt_s[i]  = 6'd0;
      end else begin
        case (state_r[i])
          ST_SEARCH: begin
            if (lane_hit_s[i]) begin
              state_s[i]     = ST_VERIFY;
              match_cnt_s[i] = 8'd1;
            end else if (slip_cnt_r[i] < SLIP_MAX) begin
              bitslip_s[i]  = 1'b1;
              slip_cnt_s[i] = slip_cnt_r[i] + 6'd1;
              wait_cnt_s[i] = WAIT_INIT;
              state_s[i]    = ST_WAIT;
            end else begin
              state_s[i] = ST_FAIL;
            end
          end
          ST_WAIT: begin
            // Reaching zero returns to SEARCH on the same edge, so the next compare
            // lands SLIP_WAIT+1 edges after the slip decision.
            wait_cnt_s[i] = (wait_cnt_r[i] == 4'd0) ? 4'd0 : (wait_cnt_r[i] - 4'd1);
            if (wait_cnt_r[i] <= 4'd1) begin
              state_s[i] = ST_SEARCH;
            end else begin
              state_s[i] = ST_WAIT;
            end
          end
          ST_VERIFY: begin
            if (lane_hit_s[i]) begin
              match_cnt_s[i] = match_cnt_r[i] + 8'd1;
              if ((match_cnt_r[i] + 8'd1) >= LOCK_TGT) begin
                state_s[i] = ST_LOCKED;
              end else begin
                state_s[i] = ST_VERIFY;
              end
            end else begin
              match_cnt_s[i] = 8'd0;
              if (slip_cnt_r[i] < SLIP_MAX) begin
                bitslip_s[i]  = 1'b1;
                slip_cnt_s[i] = slip_cnt_r[i] + 6'd1;
                wait_cnt_s[i] = WAIT_INIT;
                state_s[i]    = ST_WAIT;
              end else begin
                state_s[i] = ST_FAIL;
              end
            end
          end
          ST_LOCKED: state_s[i] = ST_LOCKED;
          ST_FAIL:   state_s[i] = ST_FAIL;
          default:   state_s[i] = ST_SEARCH;
        endcase
      end
    end
  end

  // Lane state, counters and registered per-lane flags
  always_ff @(posedge clkdiv or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        state_r[i]     <= ST_SEARCH;
        wait_cnt_r[i]  <= 4'd0;
        match_cnt_r[i] <= 8'd0;
        slip_cnt_r[i]  <= 6'd0;
      end
      bitslip_r   <= 4'd0;
      aligned_r   <= 4'd0;
      train_err_r <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_r[i]     <= state_s[i];
        wait_cnt_r[i]  <= wait_cnt_s[i];
        match_cnt_r[i] <= match_cnt_s[i];
        slip_cnt_r[i]  <= slip_cnt_s[i];
        aligned_r[i]   <= (state_s[i] == ST_LOCKED);
        train_err_r[i] <= (state_s[i] == ST_FAIL);
      end
      bitslip_r <= bitslip_s;
    end
  end

  // Link lock and gated data path; payload flows one cycle behind lock
  always_ff @(posedge clkdiv or negedge rst) begin
    if (!rst) begin
      lock_r      <= 1'b0;
      dat_out_r   <= 28'd0;
      dat_valid_r <= 1'b0;
    end else begin
      lock_r      <= &aligned_r;
      dat_out_r   <= lock_r ? dat_in : 28'd0;
      dat_valid_r <= lock_r;
    end
  end

  assign bitslip   = bitslip_r;
  assign aligned   = aligned_r;
  assign train_err = train_err_r;
  assign lock      = lock_r;
  assign dat_out   = dat_out_r;
  assign dat_valid = dat_valid_r;

endmodule
